// File: rtl/shift_pkg.sv
// Shared encodings, state type and width constants for the iterative shifter.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGE_W = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage_mux.sv
// Single power-of-two shift stage: shifts acc by 2^k per op (op 2'b11 behaves as SRA).
module shift_stage_mux
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  acc,
  input  logic [1:0]         op,
  input  logic [STAGE_W-1:0] k,
  output logic [DATA_W-1:0]  shifted
);

  logic [SHAMT_W-1:0] amt;

  always_comb begin
    amt = SHAMT_W'(1) << k;
    case (op)
      OP_SLL:  shifted = acc << amt;
      OP_SRL:  shifted = acc >> amt;
      default: shifted = DATA_W'($signed(acc) >>> amt);
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative 32-bit SLL/SRA/SRL: one power-of-two stage per clock for each set shamt bit.
// Define SHIFT_SEQ_FAST_EN to compute the whole shift in the accepting cycle instead.
module shift_seq
  import shift_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  data_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  data_out
);

  state_t             state, state_nx;
  logic [DATA_W-1:0]  acc, acc_nx, data_out_nx, stage_out;
  logic [SHAMT_W-1:0] rem, rem_nx;
  logic [1:0]         op_q, op_nx;
  logic [STAGE_W-1:0] k;

  // Highest set bit of rem wins, so stages run largest first.
  always_comb begin
    k = '0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (rem[i]) k = STAGE_W'(i);
    end
  end

  shift_stage_mux u_stage (
    .acc     (acc),
    .op      (op_q),
    .k       (k),
    .shifted (stage_out)
  );

`ifdef SHIFT_SEQ_FAST_EN
  logic [DATA_W-1:0] fast_chain [SHAMT_W+1];

  assign fast_chain[0] = data_in;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_fast
    localparam int STAGE = SHAMT_W - 1 - g;
    logic [DATA_W-1:0] shifted;

    shift_stage_mux u_fast_stage (
      .acc     (fast_chain[g]),
      .op      (op),
      .k       (STAGE_W'(STAGE)),
      .shifted (shifted)
    );

    assign fast_chain[g+1] = shamt[STAGE] ? shifted : fast_chain[g];
  end
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nx    = state;
    acc_nx      = acc;
    rem_nx      = rem;
    op_nx       = op_q;
    data_out_nx = data_out;

    case (state)
      IDLE: begin
        if (start) begin
          op_nx = op;
`ifdef SHIFT_SEQ_FAST_EN
          acc_nx      = fast_chain[SHAMT_W];
          rem_nx      = '0;
          data_out_nx = fast_chain[SHAMT_W];
          state_nx    = DONE;
`else
          acc_nx = data_in;
          rem_nx = shamt;
          if (shamt == '0) begin
            data_out_nx = data_in;
            state_nx    = DONE;
          end else begin
            state_nx = SHIFT;
          end
`endif
        end
      end
      SHIFT: begin
        acc_nx = stage_out;
        rem_nx = rem & ~(SHAMT_W'(1) << k);
        if (rem_nx == '0) begin
          data_out_nx = stage_out;
          state_nx    = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: datapath registers are reset too, so an aborted op leaves data_out at zero.
      state    <= IDLE;
      acc      <= '0;
      rem      <= '0;
      op_q     <= '0;
      data_out <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      state    <= state_nx;
      acc      <= acc_nx;
      rem      <= rem_nx;
      op_q     <= op_nx;
      data_out <= data_out_nx;
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq (default iterative build).
module tb_shift_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt    (shamt),
    .data_in  (data_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op from IDLE, scramble the inputs after acceptance, and time the done pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] exp, input int lat);
    int got_lat;
    got_lat = 0;
    start   = 1'b1;
    op      = o;
    shamt   = s;
    data_in = d;
    step();
    start   = 1'b0;
    op      = ~o;
    shamt   = ~s;
    data_in = ~d;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin
        got_lat = c;
        break;
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_ready"}, 32'(ready), 32'd0);
      step();
    end
    check({tag, "_lat"}, 32'(got_lat), 32'(lat));
    check({tag, "_data"}, data_out, exp);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    step();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    check({tag, "_held"}, data_out, exp);
  endtask

  initial begin
    int n_done;
    int done_c [2];
    logic [31:0] done_d [2];

    reset   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    shamt   = 5'd0;
    data_in = 32'h0;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", data_out, 32'h0);
    reset = 1'b1;
    step();

    run_op("sra16",  2'b01, 5'd16, 32'h8000_1234, 32'hFFFF_8000, 2);
    run_op("sll31",  2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 6);
    run_op("srl0",   2'b10, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    run_op("srl4",   2'b10, 5'd4,  32'hF000_0000, 32'h0F00_0000, 2);
    run_op("sra4",   2'b01, 5'd4,  32'hF000_0000, 32'hFF00_0000, 2);
    run_op("op11",   2'b11, 5'd1,  32'h8000_0000, 32'hC000_0000, 2);
    run_op("sra31",  2'b01, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 6);
    run_op("srl5",   2'b10, 5'd5,  32'h8000_0000, 32'h0400_0000, 3);
    run_op("sll8",   2'b00, 5'd8,  32'h1234_5678, 32'h3456_7800, 2);

    // Back-to-back: start stays high through SHIFT and DONE, then is accepted in IDLE.
    n_done    = 0;
    done_c[0] = 0; done_c[1] = 0;
    done_d[0] = '0; done_d[1] = '0;
    start   = 1'b1;
    op      = 2'b00;
    shamt   = 5'd3;
    data_in = 32'h1;
    step();
    data_in = 32'h100;
    shamt   = 5'd1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) start = 1'b0;
      if (c == 4) check("b2b_ready_idle", 32'(ready), 32'd1);
      if (done) begin
        if (n_done < 2) begin
          done_c[n_done] = c;
          done_d[n_done] = data_out;
        end
        n_done++;
      end
      step();
    end
    check("b2b_count", 32'(n_done), 32'd2);
    check("b2b_first_cyc", 32'(done_c[0]), 32'd3);
    check("b2b_first_data", done_d[0], 32'h0000_0008);
    check("b2b_second_cyc", 32'(done_c[1]), 32'd6);
    check("b2b_second_data", done_d[1], 32'h0000_0200);

    // Reset mid-operation: the in-flight op is discarded without a done pulse.
    n_done  = 0;
    start   = 1'b1;
    op      = 2'b00;
    shamt   = 5'd31;
    data_in = 32'h1;
    step();
    start = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd1);
    step();
    step();
    reset = 1'b0;
    step();
    check("rstmid_ready", 32'(ready), 32'd1);
    check("rstmid_busy_after", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_data", data_out, 32'h0);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (done) n_done++;
      step();
    end
    check("rstmid_no_done", 32'(n_done), 32'd0);
    run_op("post_rst", 2'b10, 5'd2, 32'h0000_00F0, 32'h0000_003C, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
